// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA I/O responder: FSM states, transfer
// direction codes, data bus width and the DREQ request condition.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK,
    STROBE,
    DONE
  } dma_state_e;

  localparam logic DIR_SINK   = 1'b0;
  localparam logic DIR_SOURCE = 1'b1;
  localparam int   DB_W       = 8;

  // Source asks when enough bytes are queued (or flushing a tail); sink asks while RX has room.
  function automatic logic req_cond(input logic dir, input logic flush,
                                    input int tx_cnt, input int rx_cnt,
                                    input int thresh, input int depth);
    if (dir == DIR_SOURCE) return (tx_cnt >= thresh) || (flush && (tx_cnt > 0));
    return rx_cnt < depth;
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO with registered count; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module dma_sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dma_io_responder.sv
// Peripheral side of an 8237A DMA channel: raises DREQ, answers DACK-qualified
// IOR_N/IOW_N strobes on DB, and bridges bytes to local TX/RX valid/ready streams.
module dma_io_responder
  import dma_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TX_THRESH = 4,
  parameter bit DREQ_POL  = 1'b1,
  parameter bit DACK_POL  = 1'b0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            enable,
  input  logic            dir,
  input  logic            flush,
  output logic            DREQ,
  input  logic            DACK,
  input  logic            IOR_N,
  input  logic            IOW_N,
  input  logic            EOP_N,
  inout  wire [DB_W-1:0]  DB,
  input  logic [DB_W-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [DB_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            tc,
  output logic            underrun,
  output logic            overrun,
  input  logic            clr_status
);

  localparam int CW = $clog2(DEPTH) + 1;

  dma_state_e      state_q, state_d;
  logic            dreq_q, dreq_d;
  logic            pend_q, pend_d;
  logic            tc_q, tc_d;
  logic            underrun_q, underrun_d;
  logic            overrun_q, overrun_d;
  logic [DB_W-1:0] cap_q, cap_d;
  logic [DB_W-1:0] db_out_q, db_out_d;

  logic            sel, eop, dir_strobe_n, other_n;
  logic            commit, src_commit, snk_commit, tc_set;
  logic            req_now, req_after, db_oe;
  logic            tx_push, tx_pop, tx_full, tx_empty;
  logic            rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0]   tx_cnt, rx_cnt;
  logic [DB_W-1:0] tx_head, rx_head;
  int              tx_cnt_nx, rx_cnt_nx;

  assign sel          = (DACK == DACK_POL);
  assign eop          = sel && !EOP_N;
  assign dir_strobe_n = (dir == DIR_SOURCE) ? IOR_N : IOW_N;
  assign other_n      = (dir == DIR_SOURCE) ? IOW_N : IOR_N;

  // A strobe commits on its rising sample, including one left in flight when EOP arrived.
  assign commit = enable && sel && dir_strobe_n && other_n &&
                  ((state_q == STROBE) || ((state_q == DONE) && pend_q));
  assign src_commit = commit && (dir == DIR_SOURCE);
  assign snk_commit = commit && (dir == DIR_SINK);

  assign tx_pop   = src_commit && !tx_empty;
  assign tx_ready = !tx_full || tx_pop;
  assign tx_push  = tx_valid && tx_ready;
  assign rx_pop   = !rx_empty && rx_ready;
  assign rx_push  = snk_commit && (!rx_full || rx_pop);

  assign tx_cnt_nx = int'(tx_cnt) + int'(tx_push) - int'(tx_pop);
  assign rx_cnt_nx = int'(rx_cnt) + int'(rx_push) - int'(rx_pop);
  assign req_now   = req_cond(dir, flush, int'(tx_cnt), int'(rx_cnt), TX_THRESH, DEPTH);
  assign req_after = req_cond(dir, flush, tx_cnt_nx, rx_cnt_nx, TX_THRESH, DEPTH);

  assign db_oe = enable && sel && (dir == DIR_SOURCE) && !IOR_N && IOW_N &&
                 ((state_q == ACK) || (state_q == STROBE) || ((state_q == DONE) && pend_q));
  assign DB    = db_oe ? db_out_q : {DB_W{1'bz}};

  assign DREQ     = dreq_q ? DREQ_POL : ~DREQ_POL;
  assign rx_valid = !rx_empty;
  assign rx_data  = rx_empty ? '0 : rx_head;
  assign tc       = tc_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

  always_comb begin
    state_d = state_q;
    dreq_d  = dreq_q;
    pend_d  = pend_q;
    tc_set  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      dreq_d  = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_now) begin
            state_d = REQ;
            dreq_d  = 1'b1;
          end
        end
        REQ: begin
          if (sel) state_d = ACK;
        end
        ACK: begin
          if (!sel) begin
            state_d = req_now ? REQ : IDLE;
            dreq_d  = req_now;
          end else if (!dir_strobe_n && other_n) begin
            state_d = STROBE;
          end
        end
        STROBE: begin
          if (!sel) begin
            state_d = IDLE;
            dreq_d  = 1'b0;
          end else if (commit) begin
            state_d = ACK;
            dreq_d  = req_after;
          end else if (!other_n) begin
            state_d = ACK;
          end
        end
        DONE: begin
          if (commit || !sel) pend_d = 1'b0;
          if (clr_status) begin
            state_d = IDLE;
            pend_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          dreq_d  = 1'b0;
          pend_d  = 1'b0;
        end
      endcase
      // Terminal count ends the block but lets the current strobe finish.
      if (eop && ((state_q == REQ) || (state_q == ACK) || (state_q == STROBE))) begin
        tc_set  = 1'b1;
        dreq_d  = 1'b0;
        state_d = DONE;
        pend_d  = (state_q == STROBE) && !commit;
      end
    end
  end

  always_comb begin
    tc_d       = clr_status ? 1'b0 : (tc_q | tc_set);
    underrun_d = clr_status ? 1'b0 : (underrun_q | (src_commit && tx_empty));
    overrun_d  = clr_status ? 1'b0 : (overrun_q | (snk_commit && rx_full && !rx_pop));
    cap_d      = (sel && !IOW_N && IOR_N) ? DB : cap_q;
    db_out_d   = tx_empty ? 8'hFF : tx_head;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      dreq_q     <= 1'b0;
      pend_q     <= 1'b0;
      tc_q       <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      cap_q      <= '0;
      db_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      dreq_q     <= dreq_d;
      pend_q     <= pend_d;
      tc_q       <= tc_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      cap_q      <= cap_d;
      db_out_q   <= db_out_d;
    end
  end

  dma_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DB_W)) u_tx_fifo (
    .clk   (CLK),
    .reset (RESET),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt),
    .head  (tx_head)
  );

  dma_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DB_W)) u_rx_fifo (
    .clk   (CLK),
    .reset (RESET),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (cap_q),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt),
    .head  (rx_head)
  );

endmodule

// File: tb/tb_dma_io_responder.sv
// Directed bench for dma_io_responder: source/sink transfers, overrun, EOP,
// ignored strobes and reset in the middle of a strobe.
module tb_dma_io_responder;
  import dma_pkg::*;

  logic       clk = 1'b0;
  logic       reset, enable, dir, flush, dack, ior_n, iow_n, eop_n;
  logic       dreq, tx_valid, tx_ready, rx_valid, rx_ready;
  logic       tc, underrun, overrun, clr_status;
  logic [7:0] tx_data, rx_data, tb_db;
  logic       tb_db_oe;
  wire  [7:0] db_bus;
  int         checks = 0;
  int         failures = 0;

  assign db_bus = tb_db_oe ? tb_db : 8'hzz;

  always #5 clk = ~clk;

  dma_io_responder dut (
    .CLK(clk), .RESET(reset), .enable(enable), .dir(dir), .flush(flush),
    .DREQ(dreq), .DACK(dack), .IOR_N(ior_n), .IOW_N(iow_n), .EOP_N(eop_n),
    .DB(db_bus), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tc(tc), .underrun(underrun), .overrun(overrun), .clr_status(clr_status)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    enable = 0; dir = 0; flush = 0; dack = 1; ior_n = 1; iow_n = 1; eop_n = 1;
    tx_valid = 0; tx_data = 0; rx_ready = 0; clr_status = 0; tb_db = 0; tb_db_oe = 0;
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data = b; tx_valid = 1;
    step();
    tx_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1;
    step();
    checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL reset_dreq got=%b exp=0", dreq); end
    checks++; if (dut.db_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_db_z got=%b exp=0", dut.db_oe); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if ({tc, underrun, overrun} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=000", {tc, underrun, overrun}); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
    reset = 0;
  endtask

  task automatic test_source();
    logic [7:0] exp_b;
    do_reset();
    enable = 1; dir = 1;
    for (int i = 0; i < 4; i++) push_tx(8'hA0 + 8'(i));
    checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL src_dreq_early got=%b exp=0", dreq); end
    step();
    checks++; if (dreq !== 1'b1) begin failures++; $display("[TB] FAIL src_dreq_thresh got=%b exp=1", dreq); end
    dack = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'hA0 + 8'(i);
      ior_n = 0;
      step();
      checks++; if (db_bus !== exp_b) begin failures++; $display("[TB] FAIL src_db[%0d] got=%h exp=%h", i, db_bus, exp_b); end
      ior_n = 1;
      step();
    end
    checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL src_dreq_after got=%b exp=0", dreq); end
    checks++; if (dut.tx_cnt !== 5'd0) begin failures++; $display("[TB] FAIL src_tx_empty got=%0d exp=0", dut.tx_cnt); end
    ior_n = 0;
    step();
    checks++; if (db_bus !== 8'hFF) begin failures++; $display("[TB] FAIL src_underrun_db got=%h exp=ff", db_bus); end
    ior_n = 1;
    step();
    checks++; if (underrun !== 1'b1) begin failures++; $display("[TB] FAIL src_underrun got=%b exp=1", underrun); end
    clr_status = 1;
    step();
    clr_status = 0;
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL src_underrun_clr got=%b exp=0", underrun); end
    dack = 1; enable = 0;
    step();
  endtask

  task automatic test_sink();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    do_reset();
    enable = 1; dir = 0;
    step();
    checks++; if (dreq !== 1'b1) begin failures++; $display("[TB] FAIL snk_dreq got=%b exp=1", dreq); end
    dack = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      tb_db = vals[i]; tb_db_oe = 1; iow_n = 0;
      step();
      iow_n = 1;
      step();
      tb_db_oe = 0;
    end
    checks++; if (dreq !== 1'b1) begin failures++; $display("[TB] FAIL snk_dreq_hold got=%b exp=1", dreq); end
    rx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({rx_valid, rx_data} !== {1'b1, vals[i]}) begin failures++; $display("[TB] FAIL snk_rx[%0d] got=%b/%h exp=1/%h", i, rx_valid, rx_data, vals[i]); end
      step();
    end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL snk_rx_drained got=%b exp=0", rx_valid); end
    rx_ready = 0; dack = 1; enable = 0;
    step();
  endtask

  task automatic test_overrun();
    do_reset();
    enable = 1; dir = 0;
    step();
    dack = 0;
    step();
    for (int i = 0; i < 16; i++) begin
      tb_db = 8'h10 + 8'(i); tb_db_oe = 1; iow_n = 0;
      step();
      iow_n = 1;
      step();
    end
    checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL ovr_dreq_full got=%b exp=0", dreq); end
    tb_db = 8'h5A; iow_n = 0;
    step();
    iow_n = 1;
    step();
    tb_db_oe = 0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL ovr_flag got=%b exp=1", overrun); end
    checks++; if (dut.rx_cnt !== 5'd16) begin failures++; $display("[TB] FAIL ovr_count got=%0d exp=16", dut.rx_cnt); end
    checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL ovr_dreq got=%b exp=0", dreq); end
    checks++; if (rx_data !== 8'h10) begin failures++; $display("[TB] FAIL ovr_head got=%h exp=10", rx_data); end
    clr_status = 1;
    step();
    clr_status = 0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL ovr_clr got=%b exp=0", overrun); end
    dack = 1; enable = 0;
    step();
  endtask

  task automatic test_eop();
    do_reset();
    enable = 1; dir = 1;
    for (int i = 0; i < 4; i++) push_tx(8'hB0 + 8'(i));
    step();
    dack = 0;
    step();
    ior_n = 0;
    step();
    checks++; if (db_bus !== 8'hB0) begin failures++; $display("[TB] FAIL eop_db0 got=%h exp=b0", db_bus); end
    ior_n = 1;
    step();
    ior_n = 0;
    step();
    eop_n = 0;
    step();
    eop_n = 1;
    checks++; if (db_bus !== 8'hB1) begin failures++; $display("[TB] FAIL eop_db1 got=%h exp=b1", db_bus); end
    ior_n = 1;
    step();
    checks++; if (tc !== 1'b1) begin failures++; $display("[TB] FAIL eop_tc got=%b exp=1", tc); end
    checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL eop_dreq got=%b exp=0", dreq); end
    checks++; if (dut.state_q !== DONE) begin failures++; $display("[TB] FAIL eop_state got=%0d exp=%0d", dut.state_q, DONE); end
    checks++; if (dut.tx_cnt !== 5'd2) begin failures++; $display("[TB] FAIL eop_popped got=%0d exp=2", dut.tx_cnt); end
    enable = 0;
    step();
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL eop_idle got=%0d exp=%0d", dut.state_q, IDLE); end
    checks++; if (tc !== 1'b1) begin failures++; $display("[TB] FAIL eop_tc_sticky got=%b exp=1", tc); end
    dack = 1;
    step();
  endtask

  task automatic test_ignored();
    do_reset();
    enable = 1; dir = 1;
    push_tx(8'hC0);
    push_tx(8'hC1);
    step();
    checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL ign_dreq_below got=%b exp=0", dreq); end
    ior_n = 0;
    step();
    checks++; if (dut.db_oe !== 1'b0) begin failures++; $display("[TB] FAIL ign_nodack_db got=%b exp=0", dut.db_oe); end
    ior_n = 1;
    step();
    checks++; if (dut.tx_cnt !== 5'd2) begin failures++; $display("[TB] FAIL ign_nodack_pop got=%0d exp=2", dut.tx_cnt); end
    flush = 1;
    step();
    checks++; if (dreq !== 1'b1) begin failures++; $display("[TB] FAIL ign_flush_dreq got=%b exp=1", dreq); end
    dack = 0;
    step();
    ior_n = 0; iow_n = 0;
    step();
    checks++; if (dut.db_oe !== 1'b0) begin failures++; $display("[TB] FAIL ign_both_db got=%b exp=0", dut.db_oe); end
    ior_n = 1; iow_n = 1;
    step();
    checks++; if (dut.tx_cnt !== 5'd2) begin failures++; $display("[TB] FAIL ign_both_pop got=%0d exp=2", dut.tx_cnt); end
    checks++; if ({tc, underrun, overrun} !== 3'b000) begin failures++; $display("[TB] FAIL ign_flags got=%b exp=000", {tc, underrun, overrun}); end
    flush = 0; dack = 1; enable = 0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1; dir = 1;
    for (int i = 0; i < 3; i++) push_tx(8'hD0 + 8'(i));
    flush = 1;
    step();
    dack = 0;
    step();
    ior_n = 0;
    step();
    checks++; if (dut.state_q !== STROBE) begin failures++; $display("[TB] FAIL rst_mid_pre got=%0d exp=%0d", dut.state_q, STROBE); end
    reset = 1;
    step();
    checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_dreq got=%b exp=0", dreq); end
    checks++; if (dut.db_oe !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_db got=%b exp=0", dut.db_oe); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_tx_ready got=%b exp=1", tx_ready); end
    checks++; if (dut.tx_cnt !== 5'd0) begin failures++; $display("[TB] FAIL rst_mid_tx_cnt got=%0d exp=0", dut.tx_cnt); end
    checks++; if ({tc, underrun, overrun} !== 3'b000) begin failures++; $display("[TB] FAIL rst_mid_flags got=%b exp=000", {tc, underrun, overrun}); end
    reset = 0; ior_n = 1; dack = 1; enable = 0; flush = 0;
    step();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_source();
    test_sink();
    test_overrun();
    test_eop();
    test_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
